pid_ch_scheduler: RTL and testbench

- Time-shares one incremental-PID datapath among CH_NUM independent control loops.
- Each loop raises a request carrying its target and measured value. A round-robin arbiter grants one loop at a time.
- The block evaluates du = kp·(e0−e1) + ki·e0 + kd·(e0−2e1+e2) with a single shared multiplier over three cycles.
- Each channel keeps its own e(k−1), e(k−2) and u(k−1) history, and the block returns a saturated u(k) tagged with the channel index.

---
 rtl/pid_ch_scheduler_if.sv | 18 +
 rtl/pid_ch_scheduler.sv | 130 +++++++++++++
 tb/tb_pid_ch_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pid_ch_scheduler_if.sv
// pid_ch_scheduler_if: request/gain/result bundle between control loops and the PID scheduler
interface pid_ch_scheduler_if #(parameter int CH_NUM = 4, parameter int DW = 10, parameter int PW = 8, parameter int OW = 16);
  localparam int CW = $clog2(CH_NUM);
  logic [CH_NUM-1:0] req;
  logic [CH_NUM*DW-1:0] target;
  logic [CH_NUM*DW-1:0] y;
  logic [PW-1:0] kp;
  logic [PW-1:0] ki;
  logic [PW-1:0] kd;
  logic [CH_NUM-1:0] ch_clr;
  logic [CH_NUM-1:0] ack;
  logic busy;
  logic out_valid;
  logic [CW-1:0] out_ch;
  logic signed [OW-1:0] uk;
  modport master (output req, target, y, kp, ki, kd, ch_clr, input ack, busy, out_valid, out_ch, uk);
  modport slave (input req, target, y, kp, ki, kd, ch_clr, output ack, busy, out_valid, out_ch, uk);
endinterface

// File: rtl/pid_ch_scheduler.sv
// pid_ch_scheduler: round-robin time-shared incremental PID with one multiplier and per-channel history
module pid_ch_scheduler #(parameter int CH_NUM = 4, parameter int DW = 10, parameter int PW = 8, parameter int OW = 16) (
  input logic clk,
  input logic rst_n,
  pid_ch_scheduler_if.slave bus
);
  localparam int CW = $clog2(CH_NUM);
  localparam int EW = DW + 1;
  localparam int XW = DW + 3;
  localparam int MW = PW + DW + 4;
  localparam int AW = PW + DW + 6;
  localparam int SW = (OW > AW ? OW : AW) + 1;
  localparam logic signed [SW-1:0] SMAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, ERR, MP, MI, MD, UPD} state_t;
  state_t state;
  logic [CW-1:0] ptr, g, gnt;
  logic gnt_ok;
  int j;
  logic signed [DW-1:0] t_l, y_l;
  logic [PW-1:0] kp_l, ki_l, kd_l, gain;
  logic signed [EW-1:0] e0;
  logic signed [EW-1:0] e1 [CH_NUM];
  logic signed [EW-1:0] e2 [CH_NUM];
  logic signed [OW-1:0] u [CH_NUM];
  logic signed [XW-1:0] dp, dd, opd;
  logic signed [MW-1:0] prod;
  logic signed [AW-1:0] acc;
  logic signed [SW-1:0] sum;
  logic signed [OW-1:0] sat;
  // search downward so the channel nearest ptr+1 is the last, winning assignment
  always_comb begin
    gnt = '0;
    gnt_ok = 1'b0;
    j = 0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      j = (int'(ptr) + 1 + k) % CH_NUM;
      if (bus.req[j[CW-1:0]]) begin
        gnt = j[CW-1:0];
        gnt_ok = 1'b1;
      end
    end
  end
  always_comb begin
    dp = XW'(e0) - XW'(e1[g]);
    dd = XW'(e0) - (XW'(e1[g]) <<< 1) + XW'(e2[g]);
    gain = state == MP ? kp_l : state == MI ? ki_l : kd_l;
    opd = state == MP ? dp : state == MI ? XW'(e0) : dd;
    prod = MW'($signed({1'b0, gain})) * MW'(opd);
    sum = SW'(u[g]) + SW'(acc);
    sat = sum > SMAX ? SMAX[OW-1:0] : sum < SMIN ? SMIN[OW-1:0] : sum[OW-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= CW'(CH_NUM - 1);
      g <= '0;
      t_l <= '0;
      y_l <= '0;
      kp_l <= '0;
      ki_l <= '0;
      kd_l <= '0;
      e0 <= '0;
      acc <= '0;
      bus.ack <= '0;
      bus.busy <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_ch <= '0;
      bus.uk <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        e1[i] <= '0;
        e2[i] <= '0;
        u[i] <= '0;
      end
    end else begin
      bus.ack <= '0;
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: if (gnt_ok) begin
          bus.ack <= {{(CH_NUM-1){1'b0}}, 1'b1} << gnt;
          bus.busy <= 1'b1;
          ptr <= gnt;
          g <= gnt;
          t_l <= bus.target[gnt*DW +: DW];
          y_l <= bus.y[gnt*DW +: DW];
          kp_l <= bus.kp;
          ki_l <= bus.ki;
          kd_l <= bus.kd;
          state <= ERR;
        end
        ERR: begin
          e0 <= EW'(t_l) - EW'(y_l);
          acc <= '0;
          state <= MP;
        end
        MP: begin
          acc <= acc + AW'(prod);
          state <= MI;
        end
        MI: begin
          acc <= acc + AW'(prod);
          state <= MD;
        end
        MD: begin
          acc <= acc + AW'(prod);
          state <= UPD;
        end
        default: begin
          bus.out_valid <= 1'b1;
          bus.out_ch <= g;
          bus.uk <= sat;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
      endcase
      // a clear on the writeback edge wins over the history update
      for (int i = 0; i < CH_NUM; i++) begin
        if (bus.ch_clr[i]) begin
          e1[i] <= '0;
          e2[i] <= '0;
          u[i] <= '0;
        end else if (state == UPD && g == CW'(i)) begin
          u[i] <= sat;
          e2[i] <= e1[i];
          e1[i] <= e0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pid_ch_scheduler.sv
// tb_pid_ch_scheduler: directed checks of arbitration, PID arithmetic, saturation, clear and reset abort
module tb_pid_ch_scheduler;
  localparam int CH = 4;
  localparam int DW = 10;
  localparam int PW = 8;
  localparam int OW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pid_ch_scheduler_if #(.CH_NUM(CH), .DW(DW), .PW(PW), .OW(OW)) bus ();
  pid_ch_scheduler #(.CH_NUM(CH), .DW(DW), .PW(PW), .OW(OW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic do_req(input string tag, input int ch, input int t, input int yv, input int exp, input int clr_at = -1);
    int n;
    bus.target[ch*DW +: DW] = t[DW-1:0];
    bus.y[ch*DW +: DW] = yv[DW-1:0];
    bus.req[ch] = 1'b1;
    n = 0;
    while (!bus.ack[ch] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ack"}, int'(bus.ack[ch]), 1);
    bus.req[ch] = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      bus.ch_clr[ch] = (n == clr_at);
      @(negedge clk);
      n++;
    end
    bus.ch_clr[ch] = 1'b0;
    chk({tag, "_lat"}, n, 5);
    chk({tag, "_ch"}, int'(bus.out_ch), ch);
    chk({tag, "_uk"}, int'($signed(bus.uk)), exp);
    @(negedge clk);
  endtask
  task automatic rr_round(input string tag);
    int n, idx, last;
    bus.req = 4'hf;
    last = 0;
    for (int i = 0; i < CH; i++) begin
      n = 0;
      while (bus.ack == '0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      idx = -1;
      for (int c = 0; c < CH; c++) if (bus.ack[c]) idx = c;
      chk($sformatf("%s_order%0d", tag, i), idx, i);
      chk($sformatf("%s_onehot%0d", tag, i), $countones(bus.ack), 1);
      if (i > 0) chk($sformatf("%s_gap%0d", tag, i), cyc - last, 6);
      last = cyc;
      if (idx >= 0) bus.req[idx] = 1'b0;
      @(negedge clk);
    end
    n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask
  task automatic clr(input logic [CH-1:0] m);
    bus.ch_clr = m;
    @(negedge clk);
    bus.ch_clr = '0;
  endtask
  initial begin
    int n, acks, vals;
    bus.req = '0;
    bus.target = '0;
    bus.y = '0;
    bus.kp = '0;
    bus.ki = '0;
    bus.kd = '0;
    bus.ch_clr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_ch", int'(bus.out_ch), 0);
    chk("rst_uk", int'($signed(bus.uk)), 0);
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acks += int'(bus.ack != '0) + int'(bus.busy) + int'(bus.out_valid);
    end
    chk("idle_quiet", acks, 0);
    rr_round("rr1");
    rr_round("rr2");
    clr(4'hf);
    bus.kp = 8'd2;
    do_req("p1", 0, 100, 40, 120);
    do_req("p2", 0, 100, 40, 120);
    bus.kp = 8'd0;
    bus.ki = 8'd3;
    do_req("i1", 1, 10, 0, 30);
    do_req("i2", 1, 10, 0, 60);
    do_req("i3", 1, 10, 0, 90);
    clr(4'b0010);
    bus.ki = 8'd0;
    bus.kd = 8'd1;
    do_req("d1", 1, 10, 0, 10);
    do_req("d2", 1, 10, 0, 0);
    bus.kd = 8'd0;
    bus.kp = 8'd255;
    do_req("sat_hi", 2, 511, -512, 32767);
    do_req("sat_lo1", 2, -512, 511, -32768);
    do_req("sat_lo2", 2, -512, 511, -32768);
    clr(4'b0001);
    bus.kp = 8'd2;
    bus.ki = 8'd1;
    do_req("clr_upd", 0, 100, 40, 180, 4);
    do_req("clr_after", 0, 100, 40, 180);
    bus.req[0] = 1'b1;
    n = 0;
    while (!bus.ack[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_ack", int'(bus.ack[0]), 1);
    bus.req[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vals = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vals += int'(bus.out_valid) + int'(bus.busy);
    end
    chk("abort_quiet", vals, 0);
    chk("abort_uk", int'($signed(bus.uk)), 0);
    do_req("abort_hist", 0, 100, 40, 180);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
